// File: rtl/dp_pkg.sv
// Shared types and widths for the 8-bit, 16-register datapath sequencer.
// Holds the instruction layout, class encodings and the control FSM states.
package dp_pkg;

   localparam int unsigned PC_W       = 8;
   localparam int unsigned INSTR_W    = 20;
   localparam int unsigned REG_ADDR_W = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned OPC_W      = 4;
   localparam int unsigned CLS_W      = 4;

   // Instruction classes; 7..E are undefined and decode as illegal.
   typedef enum logic [CLS_W-1:0] {
      CLS_NOP  = 4'h0,
      CLS_ALU  = 4'h1,
      CLS_LDI  = 4'h2,
      CLS_JMP  = 4'h3,
      CLS_BRZ  = 4'h4,
      CLS_BRC  = 4'h5,
      CLS_CMP  = 4'h6,
      CLS_HALT = 4'hF
   } cls_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   // Field layout, MSB first: [19:16] class, [15:12] alu_op, [11:8] rd,
   // [7:4] ra, [3:0] rb; imm8 overlays ra:rb.
   typedef struct packed {
      logic [CLS_W-1:0]      cls;
      logic [OPC_W-1:0]      alu_op;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] ra;
      logic [REG_ADDR_W-1:0] rb;
   } instr_t;

   function automatic logic [DATA_W-1:0] imm8(input instr_t ir);
      return {ir.ra, ir.rb};
   endfunction

endpackage

// File: rtl/dp_decode.sv
// Combinational decode of the instruction register and FSM state into the
// datapath control inputs plus branch/halt/illegal indications.
// Ports:
//   state_i, ir_i           current FSM state and instruction register
//   flag_z_i, flag_c_i      latched flags used to resolve BRZ/BRC
//   alu_en_o .. user_write_data_o   datapath controls
//   flag_upd_o              latch ALU flags at the end of this EXEC
//   branch_taken_o          next pc comes from imm8
//   halt_o, illegal_cls_o   HALT / undefined class in EXEC
module dp_decode
   import dp_pkg::*;
(
   input  logic [1:0]            state_i,
   input  logic [INSTR_W-1:0]    ir_i,
   input  logic                  flag_z_i,
   input  logic                  flag_c_i,
   output logic                  alu_en_o,
   output logic [OPC_W-1:0]      alu_opcode_o,
   output logic [REG_ADDR_W-1:0] ra_addr_o,
   output logic [REG_ADDR_W-1:0] rb_addr_o,
   output logic [REG_ADDR_W-1:0] write_addr_o,
   output logic                  write_en_o,
   output logic [DATA_W-1:0]     user_write_data_o,
   output logic                  flag_upd_o,
   output logic                  branch_taken_o,
   output logic                  halt_o,
   output logic                  illegal_cls_o
);

   instr_t ir;
   assign ir = instr_t'(ir_i);

   // Field outputs follow the IR directly; only the strobes depend on state.
   always_comb begin
      alu_en_o          = 1'b0;
      write_en_o        = 1'b0;
      flag_upd_o        = 1'b0;
      branch_taken_o    = 1'b0;
      halt_o            = 1'b0;
      illegal_cls_o     = 1'b0;
      alu_opcode_o      = ir.alu_op;
      ra_addr_o         = ir.ra;
      rb_addr_o         = ir.rb;
      write_addr_o      = ir.rd;
      user_write_data_o = imm8(ir);
      if (state_i == ST_EXEC) begin
         case (ir.cls)
            CLS_NOP:  ;
            CLS_ALU:  begin
               alu_en_o   = 1'b1;
               write_en_o = 1'b1;
               flag_upd_o = 1'b1;
            end
            CLS_LDI:  write_en_o     = 1'b1;
            CLS_JMP:  branch_taken_o = 1'b1;
            CLS_BRZ:  branch_taken_o = flag_z_i;
            CLS_BRC:  branch_taken_o = flag_c_i;
            CLS_CMP:  flag_upd_o     = 1'b1;
            CLS_HALT: halt_o         = 1'b1;
            default:  illegal_cls_o  = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control unit: fetches instructions over a req/ack port,
// executes each in one EXEC cycle and owns all datapath control inputs.
// Ports:
//   clk, rst                async active-high reset
//   start                   begin execution at address 0 (IDLE/HALT only)
//   imem_req/addr/ack/data  instruction fetch handshake
//   alu_en .. user_write_data   datapath controls (decoded from state+IR)
//   alu_zero, alu_carry     datapath flags, latched at end of ALU/CMP EXEC
//   flag_z, flag_c, pc, halted, illegal   status
module dp_sequencer
   import dp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  imem_req,
   output logic [PC_W-1:0]       imem_addr,
   input  logic                  imem_ack,
   input  logic [INSTR_W-1:0]    imem_data,
   output logic                  alu_en,
   output logic [OPC_W-1:0]      alu_opcode,
   output logic [REG_ADDR_W-1:0] ra_addr,
   output logic [REG_ADDR_W-1:0] rb_addr,
   output logic [REG_ADDR_W-1:0] write_addr,
   output logic                  write_en,
   output logic [DATA_W-1:0]     user_write_data,
   input  logic                  alu_zero,
   input  logic                  alu_carry,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic [PC_W-1:0]       pc,
   output logic                  halted,
   output logic                  illegal
);

   state_e          state_q;
   instr_t          ir_q;
   logic [PC_W-1:0] pc_q;
   logic            imem_req_q;
   logic            flag_z_q;
   logic            flag_c_q;
   logic            halted_q;
   logic            illegal_q;

   logic            flag_upd;
   logic            branch_taken;
   logic            halt_cls;
   logic            illegal_cls;

   dp_decode u_decode (
      .state_i           (state_q),
      .ir_i              (ir_q),
      .flag_z_i          (flag_z_q),
      .flag_c_i          (flag_c_q),
      .alu_en_o          (alu_en),
      .alu_opcode_o      (alu_opcode),
      .ra_addr_o         (ra_addr),
      .rb_addr_o         (rb_addr),
      .write_addr_o      (write_addr),
      .write_en_o        (write_en),
      .user_write_data_o (user_write_data),
      .flag_upd_o        (flag_upd),
      .branch_taken_o    (branch_taken),
      .halt_o            (halt_cls),
      .illegal_cls_o     (illegal_cls)
   );

   // Control FSM, program counter and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ir_q       <= '0;
         pc_q       <= '0;
         imem_req_q <= 1'b0;
         flag_z_q   <= 1'b0;
         flag_c_q   <= 1'b0;
         halted_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_FETCH;
                  pc_q       <= '0;
                  imem_req_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_req_q && imem_ack) begin
                  ir_q       <= instr_t'(imem_data);
                  state_q    <= ST_EXEC;
                  imem_req_q <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (flag_upd) begin
                  flag_z_q <= alu_zero;
                  flag_c_q <= alu_carry;
               end
               if (illegal_cls) begin
                  illegal_q <= 1'b1;
               end
               if (halt_cls) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= 1'b1;
                  // pc+1 wraps naturally at 2^PC_W
                  pc_q       <= branch_taken ? PC_W'(imm8(ir_q)) : pc_q + PC_W'(1);
               end
            end
            ST_HALT: begin
               if (start) begin
                  state_q    <= ST_FETCH;
                  pc_q       <= '0;
                  imem_req_q <= 1'b1;
                  flag_z_q   <= 1'b0;
                  flag_c_q   <= 1'b0;
                  halted_q   <= 1'b0;
                  illegal_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // pc only moves when entering FETCH, so it doubles as the fetch address.
   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with an instruction-memory responder and a
// small register-file/ALU model (opcode 1 = subtract with borrow, else add).
module tb_dp_sequencer;
   import dp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        imem_req, imem_ack;
   logic [7:0]  imem_addr, pc, user_write_data;
   logic [19:0] imem_data;
   logic        alu_en, write_en, alu_zero, alu_carry;
   logic [3:0]  alu_opcode, ra_addr, rb_addr, write_addr;
   logic        flag_z, flag_c, halted, illegal;

   int checks = 0;
   int errors = 0;

   logic [19:0] mem [256];
   int          ack_delay = 0;
   bit          manual = 1'b0;
   logic        manual_ack = 1'b0;
   logic [7:0]  fetch_q [$];
   int          wr_cnt = 0;
   int          alu_wr_cnt = 0;
   logic [3:0]  last_alu_addr = 4'h0;
   logic [7:0]  rf [16];
   logic [8:0]  alu_res;

   always #5 clk = ~clk;

   dp_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .alu_en(alu_en), .alu_opcode(alu_opcode), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .write_addr(write_addr), .write_en(write_en), .user_write_data(user_write_data),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .flag_z(flag_z), .flag_c(flag_c),
      .pc(pc), .halted(halted), .illegal(illegal)
   );

   // Datapath model
   always_comb begin
      if (alu_opcode == 4'h1) alu_res = {1'b0, rf[ra_addr]} - {1'b0, rf[rb_addr]};
      else                    alu_res = {1'b0, rf[ra_addr]} + {1'b0, rf[rb_addr]};
   end
   assign alu_zero  = (alu_res[7:0] == 8'h00);
   assign alu_carry = alu_res[8];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      end else if (write_en) begin
         rf[write_addr] <= alu_en ? alu_res[7:0] : user_write_data;
      end
   end

   // Memory responder and write monitor, both at the falling edge
   initial begin
      int cnt;
      cnt = 0;
      imem_ack = 1'b0;
      imem_data = 20'h0;
      forever begin
         @(negedge clk);
         if (manual) begin
            imem_ack = manual_ack;
            imem_data = mem[imem_addr];
            cnt = 0;
         end else if (imem_req) begin
            if (cnt >= ack_delay) begin
               imem_ack = 1'b1;
               imem_data = mem[imem_addr];
               fetch_q.push_back(imem_addr);
               cnt = 0;
            end else begin
               imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            cnt = 0;
         end
         if (write_en) begin
            wr_cnt++;
            if (alu_en) begin
               alu_wr_cnt++;
               last_alu_addr = write_addr;
            end
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 20'hF0000;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (halted !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, cyc);
      end
   endtask

   function automatic bit seq_match(int base, logic [7:0] exp [$]);
      if (fetch_q.size() - base != exp.size()) return 1'b0;
      foreach (exp[i]) if (fetch_q[base + i] !== exp[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({imem_req, write_en, alu_en, halted, illegal, flag_z, flag_c} !== 7'b0) begin
         errors++;
         $display("FAIL reset_status: req/we/ae/h/il/z/c=%b required 0000000",
                  {imem_req, write_en, alu_en, halted, illegal, flag_z, flag_c});
      end
      checks++;
      if (pc !== 8'h00 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_pc: pc=%h addr=%h required 00/00", pc, imem_addr);
      end
      checks++;
      if ({alu_opcode, ra_addr, rb_addr, write_addr, user_write_data} !== 24'h0) begin
         errors++;
         $display("FAIL reset_ctrl: %h required 000000",
                  {alu_opcode, ra_addr, rb_addr, write_addr, user_write_data});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: imem_req=%b required 0", imem_req);
      end
   endtask

   task automatic test_program();
      int cyc, w0, a0;
      clear_mem();
      mem[0] = 20'h20105;   // LDI r1,0x05
      mem[1] = 20'h20203;   // LDI r2,0x03
      mem[2] = 20'h10312;   // ALU add r3=r1+r2
      mem[3] = 20'hF0000;   // HALT
      w0 = wr_cnt;
      a0 = alu_wr_cnt;
      pulse_start();
      run_to_halt(cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL prog_cycles: %0d active cycles, required 8", cyc);
      end
      checks++;
      if (wr_cnt - w0 != 3) begin
         errors++;
         $display("FAIL prog_writes: %0d write pulses, required 3", wr_cnt - w0);
      end
      checks++;
      if (alu_wr_cnt - a0 != 1 || last_alu_addr !== 4'h3) begin
         errors++;
         $display("FAIL prog_alu_write: count=%0d addr=%h required 1/3", alu_wr_cnt - a0, last_alu_addr);
      end
      checks++;
      if (pc !== 8'h03) begin
         errors++;
         $display("FAIL prog_halt_pc: pc=%h required 03", pc);
      end
      checks++;
      if (rf[3] !== 8'h08) begin
         errors++;
         $display("FAIL prog_r3: r3=%h required 08", rf[3]);
      end
      checks++;
      if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL prog_flags: z=%b c=%b required 0/0", flag_z, flag_c);
      end
   endtask

   task automatic test_branch();
      int cyc, f0, w0;
      // BRZ taken after CMP r1,r1 (7-7)
      clear_mem();
      mem[0] = 20'h20107; mem[1] = 20'h61011; mem[2] = 20'h40010;
      f0 = fetch_q.size();
      w0 = wr_cnt;
      pulse_start();
      run_to_halt(cyc);
      checks++;
      if (!seq_match(f0, '{8'h00, 8'h01, 8'h02, 8'h10}) || pc !== 8'h10) begin
         errors++;
         $display("FAIL brz_taken: %0d fetches, pc=%h required 4 fetches ending pc=10", fetch_q.size() - f0, pc);
      end
      checks++;
      if (flag_z !== 1'b1 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL cmp_eq_flags: z=%b c=%b required 1/0", flag_z, flag_c);
      end
      checks++;
      if (wr_cnt - w0 != 1) begin
         errors++;
         $display("FAIL cmp_no_write: %0d writes required 1", wr_cnt - w0);
      end
      // BRZ not taken after CMP r1,r2 (7-3)
      clear_mem();
      mem[0] = 20'h20107; mem[1] = 20'h20203; mem[2] = 20'h61012; mem[3] = 20'h40010;
      f0 = fetch_q.size();
      pulse_start();
      run_to_halt(cyc);
      checks++;
      if (!seq_match(f0, '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04}) || pc !== 8'h04) begin
         errors++;
         $display("FAIL brz_not_taken: %0d fetches, pc=%h required 5 fetches ending pc=04", fetch_q.size() - f0, pc);
      end
      checks++;
      if (flag_z !== 1'b0 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL cmp_ne_flags: z=%b c=%b required 0/0", flag_z, flag_c);
      end
      // BRC taken after CMP r2,r1 (3-7 borrows)
      clear_mem();
      mem[0] = 20'h20107; mem[1] = 20'h20203; mem[2] = 20'h61021; mem[3] = 20'h50020;
      f0 = fetch_q.size();
      pulse_start();
      run_to_halt(cyc);
      checks++;
      if (!seq_match(f0, '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20}) || pc !== 8'h20) begin
         errors++;
         $display("FAIL brc_taken: %0d fetches, pc=%h required 5 fetches ending pc=20", fetch_q.size() - f0, pc);
      end
      checks++;
      if (flag_z !== 1'b0 || flag_c !== 1'b1) begin
         errors++;
         $display("FAIL cmp_borrow_flags: z=%b c=%b required 0/1", flag_z, flag_c);
      end
   endtask

   task automatic test_wait_states();
      int cyc;
      clear_mem();
      mem[0] = 20'h205AA;   // LDI r5,0xAA
      ack_delay = 4;
      pulse_start();
      checks++;
      if (flag_c !== 1'b0 || flag_z !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: z=%b c=%b halted=%b required 0/0/0", flag_z, flag_c, halted);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 8'h00 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold[%0d]: req=%b addr=%h we=%b required 1/00/0", i, imem_req, imem_addr, write_en);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (write_en !== 1'b1 || alu_en !== 1'b0 || write_addr !== 4'h5 ||
          user_write_data !== 8'hAA || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL wait_exec: we=%b ae=%b wa=%h imm=%h req=%b required 1/0/5/AA/0",
                  write_en, alu_en, write_addr, user_write_data, imem_req);
      end
      run_to_halt(cyc);
      ack_delay = 0;
   endtask

   task automatic test_illegal();
      int cyc, w0;
      clear_mem();
      mem[0] = 20'h91234;   // class 9
      mem[1] = 20'h00000;   // NOP
      w0 = wr_cnt;
      pulse_start();
      @(posedge clk);
      #1;
      checks++;
      if (write_en !== 1'b0) begin
         errors++;
         $display("FAIL illegal_no_write: we=%b required 0", write_en);
      end
      @(posedge clk);
      #1;
      checks++;
      if (illegal !== 1'b1 || pc !== 8'h01) begin
         errors++;
         $display("FAIL illegal_set: illegal=%b pc=%h required 1/01", illegal, pc);
      end
      run_to_halt(cyc);
      checks++;
      if (illegal !== 1'b1 || pc !== 8'h02 || wr_cnt != w0) begin
         errors++;
         $display("FAIL illegal_sticky: illegal=%b pc=%h writes=%0d required 1/02/0", illegal, pc, wr_cnt - w0);
      end
      pulse_start();
      checks++;
      if (illegal !== 1'b0 || pc !== 8'h00 || halted !== 1'b0) begin
         errors++;
         $display("FAIL illegal_restart: illegal=%b pc=%h halted=%b required 0/00/0", illegal, pc, halted);
      end
      run_to_halt(cyc);
   endtask

   task automatic test_wrap();
      int cyc, f0;
      clear_mem();
      mem[0]     = 20'h300FF;   // JMP 0xFF
      mem[8'hFF] = 20'h00000;   // NOP
      f0 = fetch_q.size();
      pulse_start();
      cyc = 0;
      while (fetch_q.size() - f0 < 3 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (!seq_match(f0, '{8'h00, 8'hFF, 8'h00}) || pc !== 8'h00) begin
         errors++;
         $display("FAIL pc_wrap: %0d fetches, pc=%h required 0,FF,0 and pc=00", fetch_q.size() - f0, pc);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      int cyc;
      clear_mem();
      mem[0] = 20'h20105;   // LDI r1,0x05
      manual = 1'b1;
      manual_ack = 1'b0;
      pulse_start();
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_fetch_req: imem_req=%b required 1", imem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: imem_req=%b pc=%h required 0/00", imem_req, pc);
      end
      @(negedge clk);
      rst = 1'b0;
      manual_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0 || write_en !== 1'b0 || halted !== 1'b0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL late_ack_ignored: req=%b we=%b halted=%b pc=%h required 0/0/0/00",
                  imem_req, write_en, halted, pc);
      end
      manual_ack = 1'b0;
      manual = 1'b0;
      repeat (2) @(posedge clk);
      pulse_start();
      run_to_halt(cyc);
      checks++;
      if (rf[1] !== 8'h05 || pc !== 8'h01) begin
         errors++;
         $display("FAIL resume_after_reset: r1=%h pc=%h required 05/01", rf[1], pc);
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_program();
      test_branch();
      test_wait_states();
      test_illegal();
      test_wrap();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
